// File: rtl/serial_adder_pkg.sv
// Shared state encoding and index-width helper for the serial wide adder.
// No logic; latency and backpressure are properties of the users.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Slice index width; at least one bit so WORDS=1 still has a legal counter.
  function automatic int calc_idxw(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/serial_wide_adder_nbit_adder.sv
// N-bit ripple slice adder: {c_out, sum} = a + b + c_in.
// Latency 0 (combinational); no backpressure.
module Nbit_Adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};

endmodule

// File: rtl/serial_wide_adder.sv
// Adds two N*WORDS-bit operands one N-bit slice per cycle; done pulses WORDS+1 edges after start.
// Backpressure: start is ignored while busy; a start in the DONE cycle chains the next add.
module serial_wide_adder
  import serial_adder_pkg::*;
#(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic               c_in,
  output logic               busy,
  output logic               done,
  output logic [N*WORDS-1:0] sum,
  output logic               c_out
);

  localparam int W    = N * WORDS;
  localparam int IDXW = calc_idxw(WORDS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [W-1:0]    op_a_q, op_a_d;
  logic [W-1:0]    op_b_q, op_b_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            c_out_q, c_out_d;

  logic [N-1:0]    slice_a, slice_b, slice_sum;
  logic            slice_cout;

  assign slice_a = op_a_q[idx_q*N +: N];
  assign slice_b = op_b_q[idx_q*N +: N];

  Nbit_Adder #(.N(N)) ADD0 (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = b;
          carry_d = c_in;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Upper slices keep the previous result until overwritten.
        sum_d[idx_q*N +: N] = slice_sum;
        carry_d             = slice_cout;
        if (idx_q == LAST_IDX) begin
          c_out_d = slice_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule
